// File: rtl/conv_channel_sched.sv
// Output-channel sequencer for one conv layer: per channel load kernel bank, launch engine, await done.
// Optional PERF_CNT_EN macro adds a saturating pass-length counter on perf_cycles.
module conv_channel_sched #(
    parameter int OUT_CH = 8,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          conv_done,
    output logic [CW-1:0] cout,
    output logic          c_load,
    output logic          conv_start,
    output logic          busy,
`ifdef PERF_CNT_EN
    output logic          layer_done,
    output logic [15:0]   perf_cycles
`else
    output logic          layer_done
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] LAST_CH = CW'(OUT_CH - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cout_q, cout_d;
    logic          c_load_q, c_load_d;
    logic          conv_start_q, conv_start_d;
    logic          busy_q, busy_d;
    logic          layer_done_q, layer_done_d;

    always_comb begin
        state_d = state_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LOAD;
                    cout_d  = '0;
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (conv_done) begin
                    if (cout_q == LAST_CH) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        cout_d  = cout_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cout_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                cout_d  = '0;
            end
        endcase

        // abort overrides every transition out of a non-IDLE state
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cout_d  = '0;
        end
    end

    // Outputs are registered decodes of the next state, so they align with the state they describe.
    always_comb begin
        c_load_d     = (state_d == S_LOAD);
        conv_start_d = (state_d == S_START);
        busy_d       = (state_d != S_IDLE);
        layer_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cout_q       <= '0;
            c_load_q     <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cout_q       <= cout_d;
            c_load_q     <= c_load_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign cout       = cout_q;
    assign c_load     = c_load_q;
    assign conv_start = conv_start_q;
    assign busy       = busy_q;
    assign layer_done = layer_done_q;

`ifdef PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0] perf_q, perf_d;

    always_comb begin
        cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        cnt_d   = cnt_q;
        perf_d  = perf_q;
        if (state_q == S_IDLE) begin
            if (state_d == S_LOAD) cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end
        // snapshot includes the final WAIT cycle, hence the incremented value
        if ((state_d == S_DONE) && (state_q != S_DONE)) perf_d = cnt_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            perf_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_channel_sched.sv
// Directed bench for conv_channel_sched: per-cycle check against a channel/step model plus literal pins.
// Two instances: OUT_CH=8 (main tests) and OUT_CH=1 (single-channel pass).
module tb_conv_channel_sched;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       start8 = 1'b0, abort8 = 1'b0, inj8 = 1'b0, eng_done8 = 1'b0;
    logic       conv_done8;
    logic [3:0] cout8;
    logic       c_load8, conv_start8, busy8, layer_done8;

    logic       start1 = 1'b0, abort1 = 1'b0, eng_done1 = 1'b0;
    logic       conv_done1;
    logic [0:0] cout1;
    logic       c_load1, conv_start1, busy1, layer_done1;
`ifdef PERF_CNT_EN
    logic [15:0] perf8, perf1;
`endif

    assign conv_done8 = eng_done8 | inj8;
    assign conv_done1 = eng_done1;

    conv_channel_sched #(.OUT_CH(8), .CW(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .conv_done(conv_done8),
        .cout(cout8), .c_load(c_load8), .conv_start(conv_start8), .busy(busy8),
`ifdef PERF_CNT_EN
        .layer_done(layer_done8), .perf_cycles(perf8)
`else
        .layer_done(layer_done8)
`endif
    );

    conv_channel_sched #(.OUT_CH(1), .CW(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .conv_done(conv_done1),
        .cout(cout1), .c_load(c_load1), .conv_start(conv_start1), .busy(busy1),
`ifdef PERF_CNT_EN
        .layer_done(layer_done1), .perf_cycles(perf1)
`else
        .layer_done(layer_done1)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int edges = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Conv engine stand-in: conv_done pulses LAT cycles after each conv_start.
    int ecnt8 = 0, ecnt1 = 0;
    always @(posedge clk) begin
        #1;
        eng_done8 = 1'b0;
        if (!rst || !busy8) ecnt8 = 0;
        else begin
            if (ecnt8 > 0) begin
                ecnt8--;
                if (ecnt8 == 0) eng_done8 = 1'b1;
            end
            if (conv_start8) ecnt8 = LAT;
        end
        eng_done1 = 1'b0;
        if (!rst || !busy1) ecnt1 = 0;
        else begin
            if (ecnt1 > 0) begin
                ecnt1--;
                if (ecnt1 == 0) eng_done1 = 1'b1;
            end
            if (conv_start1) ecnt1 = LAT;
        end
    end

    // Model: mode 0 idle, 1 running, 2 layer-done cycle; step counts cycles since the channel's load.
    typedef struct {
        int mode;
        int ch;
        int step;
        int cyc;
        int perf;
    } mdl_t;

    function automatic mdl_t mdl_next(input mdl_t m, input int n, input logic st, input logic ab,
                                      input logic dn);
        mdl_t r = m;
        case (m.mode)
            0: if (st && !ab) begin
                r.mode = 1; r.ch = 0; r.step = 0; r.cyc = 1;
            end
            1: if (ab) begin
                r.mode = 0; r.ch = 0;
            end else if (m.step >= 2 && dn) begin
                if (m.ch == n - 1) begin
                    r.mode = 2;
                    r.perf = (m.cyc > 65535) ? 65535 : m.cyc;
                end else begin
                    r.ch = m.ch + 1; r.step = 0; r.cyc = m.cyc + 1;
                end
            end else begin
                r.step = m.step + 1; r.cyc = m.cyc + 1;
            end
            default: begin
                r.mode = 0; r.ch = 0;
            end
        endcase
        return r;
    endfunction

    mdl_t m8 = '{default: 0};
    mdl_t m1 = '{default: 0};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m8 <= '{default: 0};
            m1 <= '{default: 0};
        end else begin
            m8 <= mdl_next(m8, 8, start8, abort8, conv_done8);
            m1 <= mdl_next(m1, 1, start1, abort1, conv_done1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d8.cout", 32'(cout8), 32'(m8.ch));
            chk("d8.c_load", c_load8, (m8.mode == 1 && m8.step == 0));
            chk("d8.conv_start", conv_start8, (m8.mode == 1 && m8.step == 1));
            chk("d8.busy", busy8, (m8.mode != 0));
            chk("d8.layer_done", layer_done8, (m8.mode == 2));
            chk("d1.cout", 32'(cout1), 32'(m1.ch));
            chk("d1.c_load", c_load1, (m1.mode == 1 && m1.step == 0));
            chk("d1.conv_start", conv_start1, (m1.mode == 1 && m1.step == 1));
            chk("d1.busy", busy1, (m1.mode != 0));
            chk("d1.layer_done", layer_done1, (m1.mode == 2));
`ifdef PERF_CNT_EN
            chk("d8.perf", perf8, 32'(m8.perf));
            chk("d1.perf", perf1, 32'(m1.perf));
`endif
        end
    end

    int cl8 = 0, cs8 = 0, ld8 = 0, cl1 = 0, ld1 = 0;
    logic [3:0] log8[$];
    always @(negedge clk) begin
        if (c_load8) begin
            cl8++;
            log8.push_back(cout8);
        end
        if (conv_start8) cs8++;
        if (layer_done8) ld8++;
        if (c_load1) cl1++;
        if (layer_done1) ld1++;
    end

    task automatic step(input int k = 1);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wait_ld8(input int budget, input string name);
        int i = 0;
        while (!layer_done8 && i < budget) begin
            step();
            i++;
        end
        chk(name, layer_done8, 1'b1);
    endtask

    task automatic wait_wait8(input int ch, input string name);
        int i = 0;
        while (!(cout8 == 4'(ch) && busy8 && !c_load8 && !conv_start8) && i < 100) begin
            step();
            i++;
        end
        chk(name, (cout8 == 4'(ch) && busy8 && !c_load8 && !conv_start8), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected finish", edges);
        $fatal(1);
    end

    initial begin
        int t0, b_cl, b_cs, b_ld, i;
        step(3);
        chk("rst.cout", 32'(cout8), 0);
        chk("rst.c_load", c_load8, 0);
        chk("rst.conv_start", conv_start8, 0);
        chk("rst.busy", busy8, 0);
        chk("rst.layer_done", layer_done8, 0);
`ifdef PERF_CNT_EN
        chk("rst.perf", perf8, 0);
`endif
        rst = 1'b1;
        step(2);
        chk_en = 1'b1;

        // Full pass, engine latency 3
        b_cl = cl8; b_cs = cs8; b_ld = ld8;
        log8.delete();
        start8 = 1'b1;
        step();
        t0 = edges;
        start8 = 1'b0;
        chk("t1.first_c_load", c_load8, 1);
        chk("t1.first_cout", 32'(cout8), 0);
        wait_ld8(100, "t1.layer_done_seen");
        chk("t1.layer_done_latency", edges - t0, 40);
        step();
        chk("t1.cout_after", 32'(cout8), 0);
        chk("t1.busy_after", busy8, 0);
        chk("t1.c_load_count", cl8 - b_cl, 8);
        chk("t1.conv_start_count", cs8 - b_cs, 8);
        chk("t1.layer_done_count", ld8 - b_ld, 1);
        chk("t1.log_size", log8.size(), 8);
        for (int k = 0; k < 8 && k < log8.size(); k++) chk("t1.cout_order", 32'(log8[k]), k);
`ifdef PERF_CNT_EN
        chk("t1.perf", perf8, 40);
`endif

        // conv_done outside WAIT is ignored
        inj8 = 1'b1;
        step(2);
        inj8 = 1'b0;
        chk("t2.idle_busy", busy8, 0);
        chk("t2.idle_cout", 32'(cout8), 0);
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        inj8 = 1'b1;
        chk("t2.load", c_load8, 1);
        step();
        chk("t2.start", conv_start8, 1);
        chk("t2.start_cout", 32'(cout8), 0);
        step();
        inj8 = 1'b0;
        chk("t2.in_wait", (busy8 && !c_load8 && !conv_start8), 1);
        chk("t2.wait_cout", 32'(cout8), 0);
        wait_ld8(100, "t2.layer_done_seen");
        step();

        // abort in WAIT at channel 5
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_wait8(5, "t3.reach_wait5");
        abort8 = 1'b1;
        step();
        abort8 = 1'b0;
        chk("t3.cout", 32'(cout8), 0);
        chk("t3.busy", busy8, 0);
        chk("t3.layer_done", layer_done8, 0);
        b_ld = ld8;
        step(6);
        chk("t3.no_layer_done", ld8 - b_ld, 0);
`ifdef PERF_CNT_EN
        chk("t3.perf_kept", perf8, 40);
`endif
        start8 = 1'b1;
        abort8 = 1'b1;
        step();
        abort8 = 1'b0;
        chk("t3.abort_start_idle", busy8, 0);
        step();
        start8 = 1'b0;
        chk("t3.restart_load", c_load8, 1);
        chk("t3.restart_cout", 32'(cout8), 0);
        wait_ld8(100, "t3.layer_done_seen");
        step();

        // start held high: one IDLE cycle between DONE and LOAD; toggles while busy ignored
        start8 = 1'b1;
        wait_ld8(100, "t4.first_done");
        t0 = edges;
        step();
        chk("t4.idle_gap", busy8, 0);
        step();
        chk("t4.relaunch", c_load8, 1);
        chk("t4.relaunch_gap", edges - t0, 2);
        for (i = 0; i < 10; i++) begin
            start8 = ~start8;
            step();
        end
        start8 = 1'b0;
        wait_ld8(100, "t4.second_done");
        step();

        // async reset mid-WAIT at channel 3
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_wait8(3, "t5.reach_wait3");
        rst = 1'b0;
        #1;
        chk("t5.cout", 32'(cout8), 0);
        chk("t5.busy", busy8, 0);
        chk("t5.c_load", c_load8, 0);
        chk("t5.conv_start", conv_start8, 0);
        chk("t5.layer_done", layer_done8, 0);
`ifdef PERF_CNT_EN
        chk("t5.perf", perf8, 0);
`endif
        step();
        rst = 1'b1;
        step(2);

        // single-channel instance
        b_cl = cl1; b_ld = ld1;
        start1 = 1'b1;
        step();
        t0 = edges;
        start1 = 1'b0;
        chk("t6.c_load", c_load1, 1);
        i = 0;
        while (!layer_done1 && i < 50) begin
            step();
            i++;
        end
        chk("t6.layer_done_seen", layer_done1, 1);
        chk("t6.latency", edges - t0, 5);
        chk("t6.cout", 32'(cout1), 0);
`ifdef PERF_CNT_EN
        chk("t6.perf", perf1, 5);
`endif
        step();
        chk("t6.busy_after", busy1, 0);
        chk("t6.c_load_count", cl1 - b_cl, 1);
        chk("t6.layer_done_count", ld1 - b_ld, 1);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
